// File: rtl/enum_cast_pkg.sv
// Purpose: shared enum literal table, value typedef and legality helper.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package enum_cast_pkg;

   localparam int WIDTH_DEF = 7;
   localparam int NUM_LITS  = 5;

   typedef logic [WIDTH_DEF-1:0] enum_val_t;

   localparam enum_val_t LIT_A = enum_val_t'(0);
   localparam enum_val_t LIT_B = enum_val_t'(1);
   localparam enum_val_t LIT_C = enum_val_t'(2);
   localparam enum_val_t LIT_D = enum_val_t'(100);
   localparam enum_val_t LIT_E = enum_val_t'(101);

   localparam enum_val_t LIT_TABLE [NUM_LITS] = '{LIT_A, LIT_B, LIT_C, LIT_D, LIT_E};

   // Full-width compare: a raw value whose upper bits are set never aliases onto a literal.
   function automatic logic is_legal_lit(input logic [31:0] value);
      logic legal;
      legal = 1'b0;
      for (int k = 0; k < NUM_LITS; k++) begin
         if (value == 32'(LIT_TABLE[k])) legal = 1'b1;
      end
      return legal;
   endfunction

endpackage

// File: rtl/enum_cast_arbiter_rr_arbiter.sv
// Purpose: round-robin arbiter, one-hot grant starting the search at ptr.
// Latency: purely combinational, no state.
// Backpressure: enable=0 forces grant to all-zero.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             enable,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);

   logic [IDX_W-1:0] idx;

   // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         if (32'(ptr) + 32'(k) >= 32'(N)) idx = IDX_W'(32'(ptr) + 32'(k) - 32'(N));
         else                             idx = IDX_W'(32'(ptr) + 32'(k));
         if (enable && !grant_vld && req[idx]) begin
            grant_vld  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/enum_cast_arbiter.sv
// Purpose: shares one registered enum-cast/legality stage among NUM_REQ requesters.
// Latency: 1 cycle from accept to out_valid; 1 result per cycle sustained.
// Backpressure: out_valid & ~out_ready holds the result and drops all req_ready.
module enum_cast_arbiter
   import enum_cast_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int ERR_W   = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_bits,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_bits,
   output logic                     out_legal,
   output logic [ID_W-1:0]          out_id,
   output logic [ERR_W-1:0]         err_count,
   output logic                     busy
);

   logic             can_accept;
   logic             accept;
   logic [ID_W-1:0]  gnt_idx;
   logic [ID_W-1:0]  rr_ptr;
   logic [WIDTH-1:0] raw;
   logic             raw_legal;

   assign can_accept = ~out_valid | out_ready;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .enable    (can_accept & ~reset),
      .grant     (req_ready),
      .grant_idx (gnt_idx),
      .grant_vld (accept)
   );

   assign raw       = req_bits[32'(gnt_idx)*WIDTH +: WIDTH];
   assign raw_legal = is_legal_lit(32'(raw));
   assign busy      = out_valid | (|req_valid);

   // Result register: load on accept (replaces a draining result), clear valid on bare drain.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_bits  <= '0;
         out_legal <= 1'b0;
         out_id    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_bits  <= raw;
         out_legal <= raw_legal;
         out_id    <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer moves past the winner only when something is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Saturating count of accepted illegal values.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_count <= '0;
      end else if (accept && !raw_legal && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: doc/enum_cast_arbiter.md
Name: enum_cast_arbiter

Overview:
- Shares one registered enum-cast stage among NUM_REQ requesters.
- Each requester presents a raw WIDTH-bit value. The block grants one requester per cycle, round-robin, and casts the raw value to UInt (identity on bits).
- It also classifies the value as a legal or illegal literal of the enum set {0, 1, 2, 100, 101}.
- The result is presented on a single valid/ready output with the requester id. A running illegal-value counter feeds the test harness assertions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 7, enum/UInt width in bits; must hold the largest literal (101).
- ID_W, clog2(NUM_REQ), width of the requester id.
- ERR_W, 16, width of the illegal-value counter.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_bits, input, NUM_REQ*WIDTH, per-requester raw value; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready, output, NUM_REQ, one-hot grant/accept, combinational.
- out_valid, output, 1, result register holds a result.
- out_ready, input, 1, consumer accepts the result.
- out_bits, output, WIDTH, cast result (equal to the accepted raw value).
- out_legal, output, 1, 1 if out_bits is one of {0, 1, 2, 100, 101}.
- out_id, output, ID_W, index of the requester that produced the result.
- err_count, output, ERR_W, count of accepted illegal values; saturates at all-ones.
- busy, output, 1, out_valid OR any req_valid.

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - out_valid=0, out_bits=0, out_legal=0, out_id=0.
  - err_count=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 while reset=1.
- Reset asserted mid-operation discards any held result. No partial transfer is reported.
- Slot free: can_accept = ~out_valid | out_ready.
- Grant:
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[i]=1 only for the granted i, and only when can_accept=1. Otherwise all zero.
  - At most one bit of req_ready is high.
- Accept (req_valid[i] & req_ready[i] at edge t):
  - At t+1: out_valid=1, out_bits=raw value, out_id=i, out_legal=legality of the raw value.
  - Latency is exactly 1 cycle.
  - rr_ptr becomes (i+1) mod NUM_REQ. rr_ptr does not change on cycles with no accept.
- Drain (out_valid & out_ready at edge t) with no accept in the same cycle: out_valid=0 at t+1. Other output registers keep their values.
- Simultaneous drain and accept: the new result replaces the old one with no bubble. Full throughput is 1 result per cycle.
- Backpressure: while out_valid=1 & out_ready=0, out_bits, out_legal and out_id are held stable and req_ready is all zero.
- Legality is a pure compare of the raw value against the package literal table. Raw values 3..99 and 102..127 are illegal. Upper bits are not truncated.
- err_count:
  - Increments by 1 on each accept with an illegal value, and only on accept.
  - When it is all-ones it holds; no wrap.
- Requester-side rules:
  - A requester must hold req_valid and req_bits stable until accepted.
  - A requester that drops req_valid before being granted loses nothing; the arbiter keeps no per-requester state.
- Wrap-around: the pointer wraps from NUM_REQ-1 to 0. NUM_REQ that is not a power of two uses an explicit modulo compare.

Decomposition:
- Shared package enum_cast_pkg holds:
  - Literal constants LIT_A=0, LIT_B=1, LIT_C=2, LIT_D=100, LIT_E=101, plus NUM_LITS=5.
  - WIDTH default.
  - The typedef for the enum value (WIDTH-bit).
  - A function is_legal_lit(value).
- One natural sub-module: rr_arbiter. Inputs: req, ptr, enable. Outputs: one-hot grant, grant index. It is combinational and reusable by other shared-resource controllers.
- The result register, pointer and counter live in enum_cast_arbiter.

Test Plan:
1. Reset then idle: hold reset=1 for 2 cycles, then release. Required: out_valid=0, err_count=0, req_ready=0000, busy=0.
2. Single legal value: req_valid=0001, req_bits[0]=100 (0x64), out_ready=1. Required: req_ready=0001 that cycle; next cycle out_valid=1, out_bits=0x64, out_legal=1, out_id=0; err_count stays 0.
3. Round-robin fairness: all four requesters valid continuously with values 0, 1, 2, 101, out_ready=1. Required: out_id sequence 0,1,2,3,0,1,... with one result per cycle and all out_legal=1.
4. Backpressure: one result pending, out_ready=0 for 3 cycles, req_valid=0110. Required: outputs frozen and req_ready=0000 for those cycles. Raising out_ready grants requester 1 in the same cycle; the next result appears the following cycle.
5. Illegal values and saturation: accept raw values 3, 99 and 127. Required: each gives out_legal=0 and err_count=3. With ERR_W forced to 2, a fourth illegal value leaves err_count=3.
6. Reset mid-operation: out_valid=1 with out_bits=0x65, then assert reset for 1 cycle. Required: out_valid=0 and err_count=0 the next cycle; rr_ptr=0, so the next grant with req_valid=1111 goes to requester 0.
